// File: rtl/mdu_iter_if.sv
// Request/response bundle between the execute stage and the iterative multiply/divide unit.
interface mdu_iter_if #(
    parameter int WIDTH = 32
);
    logic             in_valid;
    logic             in_ready;
    logic [2:0]       md_op;
    logic [WIDTH-1:0] md_src1;
    logic [WIDTH-1:0] md_src2;
    logic             flush;
    logic             done;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    modport master (
        output in_valid, md_op, md_src1, md_src2, flush,
        input  in_ready, done, hi, lo
    );

    modport slave (
        input  in_valid, md_op, md_src1, md_src2, flush,
        output in_ready, done, hi, lo
    );
endinterface

// File: rtl/mdu_iter.sv
// Iterative MULT/MULTU/DIV/DIVU/MTHI/MTLO unit with HI/LO registers.
// Define MDU_FAST_MUL_EN to compute multiplies with a single-cycle multiplier in FIX.
module mdu_iter #(
    parameter int WIDTH = 32
) (
    input logic       clk,
    input logic       resetn,
    mdu_iter_if.slave bus
);

`ifdef MDU_FAST_MUL_EN
    localparam bit FAST_MUL = 1'b1;
`else
    localparam bit FAST_MUL = 1'b0;
`endif

    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;

    typedef enum logic [2:0] {
        OP_MULT  = 3'b000,
        OP_MULTU = 3'b001,
        OP_DIV   = 3'b010,
        OP_DIVU  = 3'b011,
        OP_MTHI  = 3'b100,
        OP_MTLO  = 3'b101
    } md_op_t;

    state_t               state, state_nxt;
    logic [CW-1:0]        count;
    logic [2*WIDTH-1:0]   acc;       // mul: {partial, multiplier}; div: {remainder, quotient}
    logic [WIDTH-1:0]     opnd;      // multiplicand or divisor magnitude
    logic                 is_div;
    logic                 neg_q;     // negate product / quotient
    logic                 neg_r;     // negate remainder
    logic [WIDTH-1:0]     hi_q, lo_q;
    logic                 done_q;

    logic                 in_ready;
    logic                 accept;
    logic                 req_mul, req_div, req_signed;
    logic                 src1_neg, src2_neg, div_zero;
    logic [WIDTH-1:0]     src1_mag, src2_mag;

    assign in_ready   = (state == IDLE);
    assign accept     = bus.in_valid & in_ready & ~bus.flush;
    assign req_mul    = (bus.md_op[2:1] == 2'b00);
    assign req_div    = (bus.md_op[2:1] == 2'b01);
    assign req_signed = ~bus.md_op[0];
    assign src1_neg   = req_signed & bus.md_src1[WIDTH-1];
    assign src2_neg   = req_signed & bus.md_src2[WIDTH-1];
    assign src1_mag   = src1_neg ? -bus.md_src1 : bus.md_src1;
    assign src2_mag   = src2_neg ? -bus.md_src2 : bus.md_src2;
    assign div_zero   = (bus.md_src2 == '0);

    // One iteration: shift-add for multiply, restoring step for divide.
    logic [WIDTH:0]       mul_sum;
    logic [WIDTH:0]       div_shift;
    logic                 div_ge;
    logic [WIDTH-1:0]     div_diff;
    logic [2*WIDTH-1:0]   acc_step;

    assign mul_sum   = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, opnd} : '0);
    assign div_shift = acc[2*WIDTH-1:WIDTH-1];
    assign div_ge    = (div_shift >= {1'b0, opnd});
    // When the trial subtraction succeeds the true difference is below the divisor, so W bits suffice.
    assign div_diff  = div_shift[WIDTH-1:0] - opnd;

    always_comb begin
        acc_step = {mul_sum, acc[WIDTH-1:1]};
        if (is_div)
            acc_step = {(div_ge ? div_diff : div_shift[WIDTH-1:0]), acc[WIDTH-2:0], div_ge};
    end

    // Sign correction applied on the FIX edge.
    logic [2*WIDTH-1:0]   prod_raw, prod;
    logic [WIDTH-1:0]     quo, rem;

    assign prod_raw = FAST_MUL ? ({{WIDTH{1'b0}}, opnd} * {{WIDTH{1'b0}}, acc[WIDTH-1:0]}) : acc;
    assign prod     = neg_q ? -prod_raw : prod_raw;
    assign quo      = neg_q ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
    assign rem      = neg_r ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];

    // NOTE: combinational blocks assign every output a default first so no path infers a latch.
    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: begin
                if (accept) begin
                    if (req_div)
                        state_nxt = div_zero ? FIX : CALC;
                    else if (req_mul)
                        state_nxt = FAST_MUL ? FIX : CALC;
                end
            end
            CALC: begin
                if (bus.flush)
                    state_nxt = IDLE;
                else if (count == '0)
                    state_nxt = FIX;
            end
            FIX:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    // NOTE: the operand/accumulator flops are reset too, keeping X out of hi/lo after any abort.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            count  <= '0;
            acc    <= '0;
            opnd   <= '0;
            is_div <= 1'b0;
            neg_q  <= 1'b0;
            neg_r  <= 1'b0;
            hi_q   <= '0;
            lo_q   <= '0;
            done_q <= 1'b0;
        end else begin
            done_q <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (accept) begin
                        count <= CW'(WIDTH - 1);
                        case (bus.md_op)
                            OP_MTHI: hi_q <= bus.md_src1;
                            OP_MTLO: lo_q <= bus.md_src1;
                            OP_MULT, OP_MULTU: begin
                                is_div <= 1'b0;
                                opnd   <= src1_mag;
                                acc    <= {{WIDTH{1'b0}}, src2_mag};
                                neg_q  <= src1_neg ^ src2_neg;
                                neg_r  <= 1'b0;
                            end
                            OP_DIV, OP_DIVU: begin
                                is_div <= 1'b1;
                                opnd   <= src2_mag;
                                if (div_zero) begin
                                    // Pre-load the architectural div-by-zero result; FIX passes it through.
                                    acc   <= {bus.md_src1, {WIDTH{1'b1}}};
                                    neg_q <= 1'b0;
                                    neg_r <= 1'b0;
                                end else begin
                                    acc   <= {{WIDTH{1'b0}}, src1_mag};
                                    neg_q <= src1_neg ^ src2_neg;
                                    neg_r <= src1_neg;
                                end
                            end
                            default: ;
                        endcase
                    end
                end
                CALC: begin
                    if (!bus.flush) begin
                        count <= count - 1'b1;
                        acc   <= acc_step;
                    end
                end
                FIX: begin
                    if (!bus.flush) begin
                        done_q <= 1'b1;
                        if (is_div) begin
                            hi_q <= rem;
                            lo_q <= quo;
                        end else begin
                            hi_q <= prod[2*WIDTH-1:WIDTH];
                            lo_q <= prod[WIDTH-1:0];
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.in_ready = in_ready;
    assign bus.done     = done_q;
    assign bus.hi       = hi_q;
    assign bus.lo       = lo_q;

endmodule
